// File: rtl/int_ctrl_if.sv
// int_ctrl_if: 16-bit peripheral bus (cs/we/adrs/from_cpu/to_cpu) between CPU (master) and a peripheral (slave)
interface int_ctrl_if;
  logic        cs;
  logic        we;
  logic [15:0] adrs;
  logic [15:0] from_cpu;
  logic [15:0] to_cpu;
  modport master (output cs, we, adrs, from_cpu, input to_cpu);
  modport slave (input cs, we, adrs, from_cpu, output to_cpu);
endinterface

// File: rtl/int_ctrl.sv
// int_ctrl: edge-detecting, maskable, fixed-priority interrupt controller with vector/EOI bus handshake
// Ports: sys_clk/rst (async, active-low); bus = 16-bit register port (PEND, MASK, VECTOR, EOI at adrs[1:0]);
//        src_req = async request lines; irq/irq_id = prioritized request to the CPU and its source ID.
module int_ctrl #(
  parameter int N_SRC = 4
) (
  input  logic             sys_clk,
  input  logic             rst,
  int_ctrl_if.slave        bus,
  input  logic [N_SRC-1:0] src_req,
  output logic             irq,
  output logic [2:0]       irq_id
);
  typedef enum logic [1:0] {IDLE, REQ, INSERV} state_t;
  state_t state_q, state_d;
  logic [N_SRC-1:0] s0_q, s1_q, prev_q, pend_q, pend_d, mask_q, mask_d, req, w1c, ack_clr;
  logic [2:0] id_q, id_d, pri;
  logic [7:0] req8, onehot;
  logic [1:0] a;
  logic irq_q, wr, rd, vec_rd, eoi, unused_bits;
  assign a           = bus.adrs[1:0];
  assign wr          = bus.cs & bus.we;
  assign rd          = bus.cs & ~bus.we;
  assign req         = pend_q & mask_q;
  assign req8        = 8'(req);
  assign onehot      = 8'b1 << id_q;
  assign vec_rd      = rd && a == 2'd2 && state_q == REQ && req8[id_q];
  assign eoi         = wr && a == 2'd3 && state_q == INSERV;
  assign w1c         = (wr && a == 2'd0) ? bus.from_cpu[N_SRC-1:0] : '0;
  assign ack_clr     = vec_rd ? onehot[N_SRC-1:0] : '0;
  // a fresh edge beats a same-cycle W1C or acknowledge clear
  assign pend_d      = (pend_q & ~w1c & ~ack_clr) | (s1_q & ~prev_q);
  assign mask_d      = (wr && a == 2'd1) ? bus.from_cpu[N_SRC-1:0] : mask_q;
  assign unused_bits = ^{bus.adrs[15:2], bus.from_cpu[15:N_SRC]};
  assign bus.to_cpu  = a == 2'd0 ? 16'(pend_q) :
                       a == 2'd1 ? 16'(mask_q) :
                       a == 2'd2 ? {state_q == REQ, state_q == INSERV, 11'b0, id_q} : 16'h0000;
  assign irq         = irq_q;
  assign irq_id      = id_q;
  always_comb begin
    pri = 3'd0;
    for (int i = N_SRC - 1; i >= 0; i--)
      if (req[i]) pri = 3'(i);
  end
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    case (state_q)
      IDLE: begin
        state_d = |req ? REQ : IDLE;
        id_d    = |req ? pri : id_q;
      end
      // id stays frozen; losing its request cancels before any acknowledge
      REQ:     state_d = !req8[id_q] ? IDLE : vec_rd ? INSERV : REQ;
      INSERV:  state_d = eoi ? IDLE : INSERV;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      s0_q    <= '0;
      s1_q    <= '0;
      prev_q  <= '0;
      pend_q  <= '0;
      mask_q  <= '0;
      id_q    <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s0_q    <= src_req;
      s1_q    <= s0_q;
      prev_q  <= s1_q;
      pend_q  <= pend_d;
      mask_q  <= mask_d;
      id_q    <= id_d;
      irq_q   <= state_d == REQ;
    end
  end
endmodule

// File: tb/tb_int_ctrl.sv
// tb_int_ctrl: directed self-checking bench for int_ctrl (N_SRC=4)
module tb_int_ctrl;
  logic       sys_clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] src_req = '0;
  logic       irq;
  logic [2:0] irq_id;
  int checks = 0;
  int errors = 0;
  int_ctrl_if b ();
  int_ctrl #(.N_SRC(4)) dut (
    .sys_clk(sys_clk),
    .rst(rst),
    .bus(b),
    .src_req(src_req),
    .irq(irq),
    .irq_id(irq_id)
  );
  always #5 sys_clk = ~sys_clk;
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask
  task automatic wr(input logic [15:0] adr, input logic [15:0] d);
    b.cs = 1'b1;
    b.we = 1'b1;
    b.adrs = adr;
    b.from_cpu = d;
    tick(1);
    b.cs = 1'b0;
    b.we = 1'b0;
  endtask
  task automatic rd(input string tag, input logic [15:0] adr, input logic [15:0] exp);
    b.cs = 1'b1;
    b.we = 1'b0;
    b.adrs = adr;
    #1;
    chk(tag, b.to_cpu, exp);
    tick(1);
    b.cs = 1'b0;
  endtask
  initial begin
    b.cs = 1'b0;
    b.we = 1'b0;
    b.adrs = '0;
    b.from_cpu = '0;
    tick(3);
    rst = 1'b1;
    chk("reset_irq", {15'b0, irq}, 16'h0);
    chk("reset_irq_id", {13'b0, irq_id}, 16'h0);
    rd("reset_pend", 16'd0, 16'h0000);
    rd("reset_mask", 16'd1, 16'h0000);
    rd("reset_vector", 16'd2, 16'h0000);
    rd("reset_eoi", 16'd3, 16'h0000);
    wr(16'd1, 16'hFFFF);
    rd("mask_width", 16'd1, 16'h000F);
    // single source, full handshake
    wr(16'd1, 16'h0004);
    src_req[2] = 1'b1;
    tick(3);
    chk("latency_not_yet", {15'b0, irq}, 16'h0);
    tick(1);
    chk("s2_irq", {15'b0, irq}, 16'h1);
    chk("s2_id", {13'b0, irq_id}, 16'h2);
    rd("s2_vector_req", 16'd2, 16'h8002);
    chk("s2_irq_after_ack", {15'b0, irq}, 16'h0);
    rd("s2_vector_inserv", 16'd2, 16'h4002);
    rd("s2_pend_cleared", 16'd0, 16'h0000);
    wr(16'd3, 16'h0000);
    rd("s2_vector_idle", 16'd2, 16'h0002);
    chk("s2_irq_idle", {15'b0, irq}, 16'h0);
    src_req = '0;
    // simultaneous sources: lowest index first
    wr(16'd1, 16'h000F);
    src_req = 4'b1010;
    tick(4);
    chk("pri_irq", {15'b0, irq}, 16'h1);
    chk("pri_id1", {13'b0, irq_id}, 16'h1);
    rd("pri_vector1", 16'd2, 16'h8001);
    rd("pri_pend_other", 16'd0, 16'h0008);
    wr(16'd3, 16'h0000);
    chk("pri_idle_gap", {15'b0, irq}, 16'h0);
    tick(1);
    chk("pri_irq_again", {15'b0, irq}, 16'h1);
    chk("pri_id3", {13'b0, irq_id}, 16'h3);
    rd("pri_vector3", 16'd2, 16'h8003);
    wr(16'd3, 16'h0000);
    src_req = '0;
    // spurious cancel by W1C while in REQ
    wr(16'd1, 16'h0001);
    src_req[0] = 1'b1;
    tick(1);
    src_req[0] = 1'b0;
    tick(3);
    chk("spur_irq", {15'b0, irq}, 16'h1);
    chk("spur_id", {13'b0, irq_id}, 16'h0);
    wr(16'd0, 16'h0001);
    chk("spur_irq_one_more", {15'b0, irq}, 16'h1);
    tick(1);
    chk("spur_irq_dropped", {15'b0, irq}, 16'h0);
    rd("spur_vector", 16'd2, 16'h0000);
    rd("spur_pend", 16'd0, 16'h0000);
    // set beats same-cycle W1C
    wr(16'd1, 16'h0000);
    src_req[0] = 1'b1;
    tick(2);
    wr(16'd0, 16'h0001);
    rd("set_wins", 16'd0, 16'h0001);
    wr(16'd0, 16'h0001);
    rd("w1c_clears", 16'd0, 16'h0000);
    src_req = '0;
    // reset while in service, request held across release
    wr(16'd1, 16'h0004);
    src_req[2] = 1'b1;
    tick(4);
    rd("rst_pre_vector", 16'd2, 16'h8002);
    rst = 1'b0;
    b.cs = 1'b1;
    b.adrs = 16'd2;
    #1;
    chk("rst_vector_async", b.to_cpu, 16'h0000);
    chk("rst_irq_async", {15'b0, irq}, 16'h0);
    b.cs = 1'b0;
    tick(2);
    rst = 1'b1;
    rd("rst_mask_cleared", 16'd1, 16'h0000);
    wr(16'd1, 16'h0004);
    tick(1);
    chk("rst_irq_not_yet", {15'b0, irq}, 16'h0);
    tick(1);
    chk("rst_irq_again", {15'b0, irq}, 16'h1);
    chk("rst_id", {13'b0, irq_id}, 16'h2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
